// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM-stage SRAM access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam int DATA_W_DEF  = 32;
  localparam int SRAM_DW_DEF = 16;
  localparam int SRAM_AW_DEF = 18;

  // Byte address that maps onto SRAM word 0.
  localparam int unsigned BASE_ADDR_DEF = 1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half-word wait timer: loaded at the start of a phase, counts down, flags its final cycle.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WAIT_CYCLES);
    end else if (dec && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign last = (count == CW'(1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage access unit: splits each 32-bit load/store into two timed 16-bit SRAM accesses.
//   state | meaning
//   IDLE  | no access in flight; a request is latched and launched
//   LO    | low half-word on the bus for WAIT_CYCLES cycles
//   HI    | high half-word on the bus for WAIT_CYCLES cycles
//   DONE  | one-cycle completion, ready=1, inputs not sampled
module mem_stage_sram_ctrl
  import mem_pkg::*;
#(
  parameter int          DATA_W      = DATA_W_DEF,
  parameter int          SRAM_DW     = SRAM_DW_DEF,
  parameter int          SRAM_AW     = SRAM_AW_DEF,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [DATA_W-1:0]  ALU_res,
  input  logic [DATA_W-1:0]  Val_Rm,
  output logic               ready,
  output logic               freeze,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               sram_we_n
);

  mem_state_e         state;
  logic [SRAM_AW-2:0] word;
  logic [SRAM_AW-2:0] word_next;
  logic [SRAM_DW-1:0] wdata_hi;
  logic               is_wr;
  logic               req;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_last;

  assign req = MEM_R_EN | MEM_W_EN;

  // Addresses below BASE_ADDR wrap silently into the top of the SRAM.
  assign word_next = (SRAM_AW-1)'((ALU_res - DATA_W'(BASE_ADDR)) >> 2);

  assign ready  = (state == DONE) || (state == IDLE && !req);
  assign freeze = req & ~ready;

  assign cnt_load = (state == IDLE && req) || (state == LO && cnt_last);
  assign cnt_dec  = (state == LO) || (state == HI);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .dec (cnt_dec),
    .last(cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      wdata_hi   <= '0;
      is_wr      <= 1'b0;
      mem_rdata  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state      <= LO;
            word       <= word_next;
            wdata_hi   <= Val_Rm[DATA_W-1:SRAM_DW];
            is_wr      <= MEM_W_EN;
            sram_addr  <= {word_next, 1'b0};
            sram_wdata <= Val_Rm[SRAM_DW-1:0];
            sram_we_n  <= ~MEM_W_EN;
          end
        end
        LO: begin
          if (cnt_last) begin
            state      <= HI;
            sram_addr  <= {word, 1'b1};
            sram_wdata <= wdata_hi;
            if (!is_wr) mem_rdata[SRAM_DW-1:0] <= sram_rdata;
          end
        end
        HI: begin
          if (cnt_last) begin
            state     <= DONE;
            sram_we_n <= 1'b1;
            if (!is_wr) mem_rdata[DATA_W-1:SRAM_DW] <= sram_rdata;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: SRAM model plus a scoreboard of expected access results.
module tb_mem_stage_sram_ctrl;

  localparam int WAIT = 2;
  localparam int LAT  = 2 * WAIT + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_res;
  logic [31:0] Val_Rm;
  logic        ready;
  logic        freeze;
  logic [31:0] mem_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;

  logic [15:0] sram_mem [0:(1<<18)-1];

  typedef struct {
    logic        is_wr;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] shadow [logic [16:0]];
  logic [31:0] last_rdata = 32'h0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .DATA_W     (32),
    .SRAM_DW    (16),
    .SRAM_AW    (18),
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_EN  (MEM_R_EN),
    .MEM_W_EN  (MEM_W_EN),
    .ALU_res   (ALU_res),
    .Val_Rm    (Val_Rm),
    .ready     (ready),
    .freeze    (freeze),
    .mem_rdata (mem_rdata),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_we_n (sram_we_n)
  );

  assign sram_rdata = sram_mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      @(negedge clk);
      check_val("idle_ready", 64'(ready), 64'(1));
      check_val("idle_freeze", 64'(freeze), 64'(0));
      check_val("idle_we_n", 64'(sram_we_n), 64'(1));
    end
  endtask

  // Issues one request at the next cycle and follows it to completion; inputs stay
  // held through DONE unless mid_change perturbs them during the first HI cycle.
  task automatic access(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] wd, input bit mid_change);
    exp_t e;
    exp_t got_e;
    int   lat;
    bit   got;
    e.is_wr = w;
    e.word  = 17'((addr - 32'd1024) >> 2);
    e.wdata = wd;
    if (w) begin
      shadow[e.word] = wd;
      e.rdata = last_rdata;
    end else begin
      e.rdata = shadow.exists(e.word) ? shadow[e.word] : 32'h0;
      last_rdata = e.rdata;
    end
    sb_q.push_back(e);

    @(posedge clk); #1;
    MEM_R_EN = r;
    MEM_W_EN = w;
    ALU_res  = addr;
    Val_Rm   = wd;
    @(negedge clk);
    check_val("req_ready", 64'(ready), 64'(0));
    check_val("req_freeze", 64'(freeze), 64'(1));

    lat = 0;
    got = 1'b0;
    while (!got && lat < 4 * LAT) begin
      @(posedge clk); #1;
      lat++;
      if (mid_change && lat == WAIT + 1) begin
        ALU_res = 32'h0000_2000;
        Val_Rm  = 32'h0BAD_F00D;
      end
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
      end else if (lat <= 2 * WAIT) begin
        check_val("bus_addr", 64'(sram_addr), 64'({e.word, lat > WAIT}));
        if (w) check_val("bus_wdata", 64'(sram_wdata),
                         64'(lat > WAIT ? e.wdata[31:16] : e.wdata[15:0]));
        check_val("bus_we_n", 64'(sram_we_n), 64'(!w));
        check_val("bus_freeze", 64'(freeze), 64'(1));
      end
    end
    check_val("ready_seen", 64'(got), 64'(1));
    check_val("latency", 64'(lat), 64'(LAT));
    check_val("done_we_n", 64'(sram_we_n), 64'(1));
    check_val("done_freeze", 64'(freeze), 64'(0));

    if (sb_q.size() == 0) begin
      check_val("sb_empty", 64'(0), 64'(1));
    end else begin
      got_e = sb_q.pop_front();
      if (got_e.is_wr) begin
        check_val("sram_lo", 64'(sram_mem[{got_e.word, 1'b0}]), 64'(got_e.wdata[15:0]));
        check_val("sram_hi", 64'(sram_mem[{got_e.word, 1'b1}]), 64'(got_e.wdata[31:16]));
      end
      check_val("mem_rdata", 64'(mem_rdata), 64'(got_e.rdata));
    end
  endtask

  initial begin
    rst      = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_res  = 32'h0;
    Val_Rm   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", 64'(ready), 64'(1));
    check_val("rst_we_n", 64'(sram_we_n), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_ready", 64'(ready), 64'(1));
    check_val("reset_freeze", 64'(freeze), 64'(0));
    check_val("reset_we_n", 64'(sram_we_n), 64'(1));
    check_val("reset_addr", 64'(sram_addr), 64'(0));
    check_val("reset_wdata", 64'(sram_wdata), 64'(0));
    check_val("reset_rdata", 64'(mem_rdata), 64'(0));

    // Basic store then load of the same word, plus a misaligned address alias.
    access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 1'b0);
    idle_cycles(1);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    idle_cycles(1);
    access(1'b1, 1'b0, 32'd1035, 32'h0, 1'b0);
    idle_cycles(1);

    // Back-to-back with inputs held across DONE.
    access(1'b0, 1'b1, 32'd1036, 32'h1234_5678, 1'b0);
    access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    idle_cycles(2);

    // Inputs perturbed during HI must not affect the access.
    access(1'b0, 1'b1, 32'd1044, 32'hCAFE_F00D, 1'b1);
    idle_cycles(1);
    access(1'b1, 1'b0, 32'd1044, 32'h0, 1'b1);
    idle_cycles(1);

    // Both enables is a store; load data must hold.
    access(1'b1, 1'b1, 32'd1048, 32'h0F0F_1234, 1'b0);
    idle_cycles(1);

    // Below-base address wraps to the top word.
    access(1'b0, 1'b1, 32'd1020, 32'hA5A5_5A5A, 1'b0);
    access(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
    check_val("wrap_lo", 64'(sram_mem[18'h3FFFE]), 64'(16'h5A5A));
    check_val("wrap_hi", 64'(sram_mem[18'h3FFFF]), 64'(16'hA5A5));
    idle_cycles(1);

    // Reset in the middle of a store's LO phase.
    @(posedge clk); #1;
    MEM_W_EN = 1'b1;
    ALU_res  = 32'd1040;
    Val_Rm   = 32'h7777_8888;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("midrst_lo_we_n", 64'(sram_we_n), 64'(0));
    #1;
    rst      = 1'b1;
    MEM_W_EN = 1'b0;
    #1;
    check_val("midrst_we_n", 64'(sram_we_n), 64'(1));
    check_val("midrst_ready", 64'(ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("postrst_ready", 64'(ready), 64'(1));
    check_val("postrst_we_n", 64'(sram_we_n), 64'(1));
    check_val("postrst_freeze", 64'(freeze), 64'(0));
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
